// File: rtl/cache_line_filler.sv
// -----------------------------------------------------------------------------
// cache_line_filler
//
// Fetches one cache line from a narrow memory port, one beat at a time, and
// hands the assembled line to the data-cache fill FIFO.
//
// Flow:  IDLE --(is_req)--> FETCH --(16th beat captured)--> PUSH --(fill_ready)--> IDLE
//
// Optional feature (compile-time macro FILL_TIMEOUT_EN):
//   When defined, an 8-bit watchdog counts consecutive FETCH cycles without
//   mem_ready. On reaching TIMEOUT_CYCLES the fill is abandoned: fill_error
//   pulses for one cycle, the partial line is discarded and the FSM returns
//   to IDLE. When undefined, there is no watchdog, fill_error is tied low and
//   FETCH waits for memory indefinitely.
//
// Handshakes:
//   fill_valid/fill_ready : strict valid/ready. A transfer happens on a rising
//                           edge where both are high. Once fill_valid rises,
//                           fill_data/fill_tag/fill_index hold until that
//                           transfer; fill_valid never drops without it
//                           (except on reset).
//   mem_req/mem_ready     : mem_req is held for the whole FETCH phase; every
//                           cycle with mem_ready high delivers one beat on
//                           mem_rdata for the address on mem_addr.
//   is_req/req_ack        : is_req is a level held by the cache; it is only
//                           sampled in IDLE, and acceptance is reported by a
//                           one-cycle req_ack pulse in the first FETCH cycle.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   is_req      line-fill request level from the data cache
//   req_addr    requested tag, address bits [31:14]
//   req_line    requested line index, address bits [13:6]
//   req_ack     one-cycle pulse when a request is accepted
//   busy        high in any state other than IDLE
//   mem_req     memory read strobe (FETCH only)
//   mem_addr    byte address of the current beat (0 outside FETCH)
//   mem_ready   beat-valid from memory
//   mem_rdata   beat data
//   fill_ready  fill FIFO not full
//   fill_valid  fill entry valid (PUSH only)
//   fill_data   assembled line
//   fill_tag    tag of the filled line
//   fill_index  line index of the filled line (FIFO-side fifo_addr)
//   fill_error  one-cycle pulse on a watchdog abort
//   dbg_state   current FSM state encoding (IDLE=0, FETCH=1, PUSH=2)
// -----------------------------------------------------------------------------
module cache_line_filler #(
    parameter int LINE_WIDTH     = 512,
    parameter int BEAT_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  is_req,
    input  logic [17:0]           req_addr,
    input  logic [7:0]            req_line,
    output logic                  req_ack,
    output logic                  busy,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ready,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  fill_ready,
    output logic                  fill_valid,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic [17:0]           fill_tag,
    output logic [7:0]            fill_index,
    output logic                  fill_error,
    output logic [1:0]            dbg_state
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int         BEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] PUSH  = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [3:0]            beat;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [17:0]           tag_q;
    logic [7:0]            index_q;
    logic                  req_ack_q;

    logic                  accept;
    logic                  capture;
    logic                  wd_expire;

    // -------------------------------------------------------------------------
    // Watchdog (optional)
    // -------------------------------------------------------------------------
`ifdef FILL_TIMEOUT_EN
    // The count holds the number of consecutive stalled FETCH cycles already
    // completed, so the abort fires on the edge that ends stalled cycle
    // number TIMEOUT_CYCLES.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;
    logic       fill_error_q;

    assign wd_expire = (state == FETCH) && !mem_ready && (wd_cnt == WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt       <= 8'd0;
            fill_error_q <= 1'b0;
        end else begin
            fill_error_q <= wd_expire;
            if (state != FETCH || mem_ready || wd_expire) begin
                wd_cnt <= 8'd0;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    assign fill_error = fill_error_q;
`else
    assign wd_expire  = 1'b0;
    assign fill_error = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (is_req) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    capture = 1'b1;
                    // Leaving on the edge that captures the last beat keeps
                    // mem_req from being seen for a seventeenth beat.
                    if (beat == LAST_BEAT) begin
                        state_next = PUSH;
                    end
                end else if (wd_expire) begin
                    state_next = IDLE;
                end
            end
            PUSH: begin
                if (fill_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= 4'd0;
            line_buf  <= '0;
            tag_q     <= 18'd0;
            index_q   <= 8'd0;
            req_ack_q <= 1'b0;
        end else begin
            state     <= state_next;
            req_ack_q <= accept;

            if (accept) begin
                tag_q    <= req_addr;
                index_q  <= req_line;
                beat     <= 4'd0;
                line_buf <= '0;
            end

            if (capture) begin
                // Decoded write avoids a variable part-select on line_buf.
                for (int i = 0; i < BEATS; i++) begin
                    if (beat == 4'(i)) begin
                        line_buf[i*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                    end
                end
                // Returns to 0 after the last beat instead of wrapping, so the
                // counter always starts a line at 0.
                if (beat == LAST_BEAT) begin
                    beat <= 4'd0;
                end else begin
                    beat <= beat + 4'd1;
                end
            end

            // A watchdog abort throws away whatever was collected so far.
            if (wd_expire) begin
                beat     <= 4'd0;
                line_buf <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ack    = req_ack_q;
    assign busy       = (state != IDLE);
    assign mem_req    = (state == FETCH);
    assign mem_addr   = (state == FETCH) ? {tag_q, index_q, beat, 2'b00} : 32'd0;
    assign fill_valid = (state == PUSH);
    assign fill_data  = line_buf;
    assign fill_tag   = tag_q;
    assign fill_index = index_q;
    assign dbg_state  = state;

endmodule
